// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types and constants for the ChaCha state generator
//
// Purpose: ChaCha word/state types, the generator FSM encoding and the
//          "expand 32-byte k" (SIGMA) / "expand 16-byte k" (TAU) constants.
// Ports:   none (package).
package chacha_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } gen_state_e;

  localparam word_t SIGMA0 = 32'h61707865;
  localparam word_t SIGMA1 = 32'h3320646e;
  localparam word_t SIGMA2 = 32'h79622d32;
  localparam word_t SIGMA3 = 32'h6b206574;

  localparam word_t TAU0 = 32'h61707865;
  localparam word_t TAU1 = 32'h3120646e;
  localparam word_t TAU2 = 32'h79622d36;
  localparam word_t TAU3 = 32'h6b206574;

endpackage

// File: rtl/chacha_state_pack.sv
// rtl/chacha_state_pack.sv - combinational assembly of a 16-word ChaCha input state
//
// Purpose: builds state words 0..15 (word 0 in [511:480]) from constants,
//          key, key size, block counter and nonce.
// Ports:
//   key_i      256  key words 0..7, word 0 in [255:224]
//   key256_i     1  1 = 256-bit key, 0 = 128-bit key in key_i[255:128]
//   counter_i  CTR_WIDTH  block counter
//   nonce_i    NONCE_W    nonce, first word in MSBs
//   state_o    512  assembled state
module chacha_state_pack
  import chacha_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  localparam int NONCE_W  = 128 - CTR_WIDTH
) (
  input  logic [255:0]           key_i,
  input  logic                   key256_i,
  input  logic [CTR_WIDTH-1:0]   counter_i,
  input  logic [NONCE_W-1:0]     nonce_i,
  output state_t                 state_o
);

  logic [127:0] const_w;
  logic [255:0] key_w;
  logic [127:0] ctr_nonce_w;

  assign const_w = key256_i ? {SIGMA0, SIGMA1, SIGMA2, SIGMA3}
                            : {TAU0, TAU1, TAU2, TAU3};

  // A 128-bit key fills both halves of the key area.
  assign key_w = key256_i ? key_i : {key_i[255:128], key_i[255:128]};

  generate
    if (CTR_WIDTH == 64) begin : g_ctr64
      // Low counter word comes first so word 12 is the fast-moving half.
      assign ctr_nonce_w = {counter_i[31:0], counter_i[63:32], nonce_i};
    end else begin : g_ctr32
      assign ctr_nonce_w = {counter_i, nonce_i};
    end
  endgenerate

  assign state_o = {const_w, key_w, ctr_nonce_w};

endmodule

// File: rtl/chacha_state_gen.sv
// rtl/chacha_state_gen.sv - streams ChaCha block input states for one key/nonce job
//
// Purpose: accepts a job (key, counter, nonce, block count) and emits one
//          512-bit state per accepted transfer, incrementing the counter.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cfg_valid/cfg_ready   job handshake
//   cfg_key, cfg_key256   key and key-size select
//   cfg_counter           initial block counter (CTR_WIDTH)
//   cfg_nonce             nonce (128 - CTR_WIDTH)
//   cfg_nblocks           number of blocks for the job
//   abort                 synchronous job cancel
//   st_valid/st_ready     state stream handshake
//   st_data, st_last      state words 0..15 and final-block flag
//   done                  one-cycle pulse on normal job completion
//   err                   sticky counter-overflow flag
module chacha_state_gen
  import chacha_pkg::*;
#(
  parameter int CTR_WIDTH  = 32,
  parameter int NBLK_WIDTH = 16,
  localparam int NONCE_W   = 128 - CTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [255:0]          cfg_key,
  input  logic                  cfg_key256,
  input  logic [CTR_WIDTH-1:0]  cfg_counter,
  input  logic [NONCE_W-1:0]    cfg_nonce,
  input  logic [NBLK_WIDTH-1:0] cfg_nblocks,
  input  logic                  abort,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [511:0]          st_data,
  output logic                  st_last,
  output logic                  done,
  output logic                  err
);

  gen_state_e            state_q;
  logic [255:0]          key_q;
  logic                  key256_q;
  logic [CTR_WIDTH-1:0]  ctr_q;
  logic [CTR_WIDTH-1:0]  ctr_d;
  logic [NONCE_W-1:0]    nonce_q;
  logic [NBLK_WIDTH-1:0] rem_q;
  logic [NBLK_WIDTH-1:0] rem_d;
  logic                  st_valid_q;
  logic                  st_last_q;
  logic                  done_q;
  logic                  err_q;
  state_t                packed_state;

  assign ctr_d = ctr_q + CTR_WIDTH'(1);
  assign rem_d = rem_q - NBLK_WIDTH'(1);

  assign cfg_ready = (state_q != RUN) && !abort;

  chacha_state_pack #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_pack (
    .key_i     (key_q),
    .key256_i  (key256_q),
    .counter_i (ctr_q),
    .nonce_i   (nonce_q),
    .state_o   (packed_state)
  );

  // Latched fields only change on a transfer, so the output is stable under
  // backpressure; gating keeps st_data at zero whenever nothing is offered.
  assign st_data  = st_valid_q ? packed_state : '0;
  assign st_valid = st_valid_q;
  assign st_last  = st_last_q;
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      key256_q   <= 1'b0;
      ctr_q      <= '0;
      nonce_q    <= '0;
      rem_q      <= '0;
      st_valid_q <= 1'b0;
      st_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q    <= IDLE;
        st_valid_q <= 1'b0;
        st_last_q  <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ERR: begin
            if (cfg_valid) begin
              key_q    <= cfg_key;
              key256_q <= cfg_key256;
              ctr_q    <= cfg_counter;
              nonce_q  <= cfg_nonce;
              rem_q    <= cfg_nblocks;
              err_q    <= 1'b0;
              if (cfg_nblocks != '0) begin
                state_q    <= RUN;
                st_valid_q <= 1'b1;
                st_last_q  <= (cfg_nblocks == NBLK_WIDTH'(1));
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (st_ready) begin
              if (rem_q == NBLK_WIDTH'(1)) begin
                state_q    <= IDLE;
                st_valid_q <= 1'b0;
                st_last_q  <= 1'b0;
                done_q     <= 1'b1;
              end else if (&ctr_q) begin
                // More blocks wanted but the counter would wrap: stop here.
                state_q    <= ERR;
                st_valid_q <= 1'b0;
                st_last_q  <= 1'b0;
                err_q      <= 1'b1;
              end else begin
                ctr_q     <= ctr_d;
                rem_q     <= rem_d;
                st_last_q <= (rem_q == NBLK_WIDTH'(2));
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_state_gen.sv
// tb/tb_chacha_state_gen.sv - scoreboard bench for chacha_state_gen (32- and 64-bit counters)
module tb_chacha_state_gen;

  logic clk;
  logic reset;

  logic         cfg_valid_a, cfg_ready_a, cfg_key256_a, abort_a;
  logic [255:0] cfg_key_a;
  logic [31:0]  cfg_counter_a;
  logic [95:0]  cfg_nonce_a;
  logic [15:0]  cfg_nblocks_a;
  logic         st_valid_a, st_ready_a, st_last_a, done_a, err_a;
  logic [511:0] st_data_a;

  logic         cfg_valid_b, cfg_ready_b, cfg_key256_b, abort_b;
  logic [255:0] cfg_key_b;
  logic [63:0]  cfg_counter_b;
  logic [63:0]  cfg_nonce_b;
  logic [15:0]  cfg_nblocks_b;
  logic         st_valid_b, st_ready_b, st_last_b, done_b, err_b;
  logic [511:0] st_data_b;

  chacha_state_gen #(.CTR_WIDTH(32), .NBLK_WIDTH(16)) u_dut32 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .cfg_key(cfg_key_a), .cfg_key256(cfg_key256_a), .cfg_counter(cfg_counter_a),
    .cfg_nonce(cfg_nonce_a), .cfg_nblocks(cfg_nblocks_a), .abort(abort_a),
    .st_valid(st_valid_a), .st_ready(st_ready_a), .st_data(st_data_a),
    .st_last(st_last_a), .done(done_a), .err(err_a)
  );

  chacha_state_gen #(.CTR_WIDTH(64), .NBLK_WIDTH(16)) u_dut64 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cfg_key(cfg_key_b), .cfg_key256(cfg_key256_b), .cfg_counter(cfg_counter_b),
    .cfg_nonce(cfg_nonce_b), .cfg_nblocks(cfg_nblocks_b), .abort(abort_b),
    .st_valid(st_valid_b), .st_ready(st_ready_b), .st_data(st_data_b),
    .st_last(st_last_b), .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int done_cnt_a, done_cnt_b;
  logic [512:0] q_a[$];
  logic [512:0] q_b[$];
  logic [512:0] prev_a, prev_b;
  bit stall_a, stall_b;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string name, input logic [512:0] act, input logic [512:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: state words built straight from the ChaCha layout rules.
  function automatic logic [511:0] model_state(input logic [255:0] key, input bit k256,
                                               input logic [63:0] ctr, input logic [127:0] nonce,
                                               input bit wide);
    logic [31:0]  w[16];
    logic [511:0] r;
    w[0] = 32'h61707865;
    w[1] = k256 ? 32'h3320646e : 32'h3120646e;
    w[2] = k256 ? 32'h79622d32 : 32'h79622d36;
    w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      w[4+i] = k256 ? key[255-32*i -: 32] : key[255-32*(i%4) -: 32];
    if (!wide) begin
      w[12] = ctr[31:0];  w[13] = nonce[95:64]; w[14] = nonce[63:32]; w[15] = nonce[31:0];
    end else begin
      w[12] = ctr[31:0];  w[13] = ctr[63:32];   w[14] = nonce[63:32]; w[15] = nonce[31:0];
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic set_ready(input bit b, input logic v);
    if (b) st_ready_b = v; else st_ready_a = v;
  endtask

  task automatic start_job(input bit b, input logic [255:0] key, input bit k256,
                           input logic [63:0] ctr, input logic [127:0] nonce, input int n,
                           output bit exp_err, output int done_before);
    logic [64:0] maxc, c;
    maxc = b ? {1'b0, {64{1'b1}}} : {33'b0, {32{1'b1}}};
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = {1'b0, (b ? ctr : {32'b0, ctr[31:0]})} + 65'(i);
      if (c > maxc) begin
        exp_err = 1'b1;
        break;
      end
      if (b) q_b.push_back({model_state(key, k256, c[63:0], nonce, 1'b1), (i == n-1)});
      else   q_a.push_back({model_state(key, k256, c[63:0], nonce, 1'b0), (i == n-1)});
    end
    @(posedge clk); #1;
    done_before = b ? done_cnt_b : done_cnt_a;
    if (b) begin
      cfg_key_b = key; cfg_key256_b = k256; cfg_counter_b = ctr;
      cfg_nonce_b = nonce[63:0]; cfg_nblocks_b = 16'(n); cfg_valid_b = 1'b1;
      chk("cfg_ready_idle_b", cfg_ready_b, 1);
    end else begin
      cfg_key_a = key; cfg_key256_a = k256; cfg_counter_a = ctr[31:0];
      cfg_nonce_a = nonce[95:0]; cfg_nblocks_a = 16'(n); cfg_valid_a = 1'b1;
      chk("cfg_ready_idle_a", cfg_ready_a, 1);
    end
    @(posedge clk); #1;
    cfg_valid_a = 1'b0;
    cfg_valid_b = 1'b0;
    chk("err_cleared_on_accept", b ? err_b : err_a, 0);
    chk("first_valid_latency", b ? st_valid_b : st_valid_a, (n != 0));
  endtask

  task automatic finish_job(input bit b, input bit exp_err, input int done_before, input int mode);
    int cyc = 0;
    while (!(b ? (done_b || err_b) : (done_a || err_a)) && cyc < 300) begin
      case (mode)
        0:       set_ready(b, 1'b1);
        1:       set_ready(b, $urandom_range(0, 2) != 0);
        default: set_ready(b, (cyc < 7) ? pat[cyc][0] : 1'b1);
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 300) begin
      vectors++; miscompares++;
      $display("FAIL job_timeout: got no done/err within %0d cycles, required completion", cyc);
    end
    @(negedge clk); #1;
    chk("done_count", (b ? done_cnt_b : done_cnt_a) - done_before, exp_err ? 0 : 1);
    chk("err_flag", b ? err_b : err_a, exp_err);
    chk("valid_low_after_job", b ? st_valid_b : st_valid_a, 0);
    chk("scoreboard_drained", b ? q_b.size() : q_a.size(), 0);
  endtask

  task automatic run_job(input bit b, input logic [255:0] key, input bit k256,
                         input logic [63:0] ctr, input logic [127:0] nonce, input int n, input int mode);
    bit e;
    int d0;
    start_job(b, key, k256, ctr, nonce, n, e, d0);
    finish_job(b, e, d0, mode);
  endtask

  initial begin
    bit e;
    int d0;
    logic [255:0] rkey;
    logic [127:0] rnonce;
    logic [63:0]  rctr;
    bit bsel;

    vectors = 0; miscompares = 0; done_cnt_a = 0; done_cnt_b = 0;
    stall_a = 0; stall_b = 0; prev_a = '0; prev_b = '0;
    reset = 1'b1;
    cfg_valid_a = 0; cfg_key_a = '0; cfg_key256_a = 0; cfg_counter_a = '0; cfg_nonce_a = '0;
    cfg_nblocks_a = '0; abort_a = 0; st_ready_a = 0;
    cfg_valid_b = 0; cfg_key_b = '0; cfg_key256_b = 0; cfg_counter_b = '0; cfg_nonce_b = '0;
    cfg_nblocks_b = '0; abort_b = 0; st_ready_b = 0;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          stall_a = 0; stall_b = 0;
        end else begin
          if (stall_a && st_valid_a) chk("hold_a", {st_data_a, st_last_a}, prev_a);
          if (st_valid_a && st_ready_a) begin
            if (q_a.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL unexpected_block_a: got %h expected none", st_data_a);
            end else chk("block_a", {st_data_a, st_last_a}, q_a.pop_front());
          end
          stall_a = st_valid_a && !st_ready_a;
          prev_a  = {st_data_a, st_last_a};
          if (done_a) done_cnt_a++;
          if (done_a || err_a) chk("done_err_exclusive_a", done_a && err_a, 0);

          if (stall_b && st_valid_b) chk("hold_b", {st_data_b, st_last_b}, prev_b);
          if (st_valid_b && st_ready_b) begin
            if (q_b.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL unexpected_block_b: got %h expected none", st_data_b);
            end else chk("block_b", {st_data_b, st_last_b}, q_b.pop_front());
          end
          stall_b = st_valid_b && !st_ready_b;
          prev_b  = {st_data_b, st_last_b};
          if (done_b) done_cnt_b++;
          if (done_b || err_b) chk("done_err_exclusive_b", done_b && err_b, 0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_valid", st_valid_a, 0);
    chk("rst_st_last", st_last_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cfg_ready", cfg_ready_a, 1);
    chk("rst_st_data", st_data_a, 0);
    chk("rst_st_data_b", st_data_b, 0);
    @(negedge clk); #1;
    reset = 1'b0;

    // RFC 8439 2.3.2 block-function input state.
    run_job(0, 256'h03020100_07060504_0b0a0908_0f0e0d0c_13121110_17161514_1b1a1918_1f1e1d1c,
            1, 64'd1, {32'h0, 96'h09000000_4a000000_00000000}, 1, 0);

    // Four blocks under a fixed backpressure pattern.
    run_job(0, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
            1, 64'h10, {$urandom(), $urandom(), $urandom(), $urandom()}, 4, 2);

    // Overflow after FFFFFFFF, then a fresh job clears err.
    run_job(0, {8{32'h01234567}}, 1, 64'hFFFF_FFFE, 128'h0, 3, 0);
    run_job(0, {8{32'h89abcdef}}, 0, 64'h5, 128'h1, 2, 1);

    // 128-bit key, 64-bit counter crossing the 32-bit boundary.
    run_job(1, {128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0}, 0, 64'h1_FFFF_FFFF,
            128'h0000_0000_0000_0000_dead_beef_cafe_f00d, 2, 0);

    // Abort under backpressure with a competing cfg_valid.
    st_ready_a = 1'b0;
    start_job(0, {8{32'h5a5a5a5a}}, 1, 64'h100, 128'h7, 5, e, d0);
    repeat (2) @(posedge clk);
    #1;
    abort_a = 1'b1; cfg_valid_a = 1'b1; cfg_nblocks_a = 16'd3;
    #1;
    chk("abort_cfg_ready_low", cfg_ready_a, 0);
    @(posedge clk); #1;
    abort_a = 1'b0; cfg_valid_a = 1'b0;
    chk("abort_valid_drop", st_valid_a, 0);
    chk("abort_err_low", err_a, 0);
    chk("abort_no_done", done_a, 0);
    q_a.delete();
    st_ready_a = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("abort_cfg_ignored", st_valid_a, 0);
    chk("abort_done_count", done_cnt_a - d0, 0);

    // Zero-length job.
    run_job(0, {8{32'h11111111}}, 1, 64'h20, 128'h2, 0, 0);

    // Asynchronous reset mid-job.
    st_ready_a = 1'b1;
    start_job(0, {8{32'h22222222}}, 1, 64'h40, 128'h3, 6, e, d0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("midrst_st_valid", st_valid_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_cfg_ready", cfg_ready_a, 1);
    chk("midrst_st_data", st_data_a, 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    run_job(0, {8{32'h33333333}}, 0, 64'h7, 128'h4, 3, 1);

    // Randomized jobs on both widths, some near counter wrap.
    for (int k = 0; k < 16; k++) begin
      bsel   = k[0];
      rkey   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rnonce = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0)
        rctr = bsel ? {32'hFFFF_FFFF, 32'hFFFF_FFFF - $urandom_range(0, 4)}
                    : {32'h0, 32'hFFFF_FFFF - $urandom_range(0, 4)};
      else
        rctr = {$urandom(), $urandom()};
      run_job(bsel, rkey, $urandom_range(0, 1) != 0, rctr, rnonce, $urandom_range(0, 6), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chacha_state_gen.md
Name: chacha_state_gen

Overview:
- Generates a stream of 512-bit ChaCha block input states for one key/nonce job, auto-incrementing the block counter per emitted block.
- Supports 256-bit and 128-bit keys (selected per job) and a build-time counter/nonce split: IETF 32/96 or original 64/64.
- Sits between the key/nonce configuration logic and the ChaCha round core. Output uses a valid/ready stream with per-job block count, last flag and counter-overflow error.

Parameters:
- CTR_WIDTH, 32, counter width in bits; legal values 32 (IETF) and 64 (original). Nonce width NONCE_W = 128 - CTR_WIDTH.
- NBLK_WIDTH, 16, width of the per-job block count.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- cfg_valid  input  1  job request
- cfg_ready  output  1  job accepted when cfg_valid && cfg_ready
- cfg_key  input  256  key as eight 32-bit words, word 0 in [255:224]; no byte swapping
- cfg_key256  input  1  1 = 256-bit key; 0 = 128-bit key in cfg_key[255:128]
- cfg_counter  input  CTR_WIDTH  initial block counter
- cfg_nonce  input  NONCE_W  nonce words, first word in MSBs
- cfg_nblocks  input  NBLK_WIDTH  blocks to emit for this job
- abort  input  1  synchronous job cancel
- st_valid  output  1  st_data holds a valid state
- st_ready  input  1  consumer accepts the state
- st_data  output  512  state words 0..15, word 0 in [511:480]
- st_last  output  1  final block of the job
- done  output  1  one-cycle pulse when a job completes normally
- err  output  1  counter overflow; sticky until next accepted job or abort

Behaviour:
- Reset values: st_valid=0, st_last=0, done=0, err=0, cfg_ready=1, st_data=0. State IDLE; all latched fields are zeroed.
- State layout:
  - Words 0-3 are the constants:
    - 256-bit key: 61707865 3320646e 79622d32 6b206574.
    - 128-bit key: 61707865 3120646e 79622d36 6b206574.
  - Words 4-11 hold the key:
    - 256-bit key: cfg_key words 0-7.
    - 128-bit key: key words 0-3 repeated in words 4-7 and again in words 8-11.
  - CTR_WIDTH=32: word 12 = counter; words 13-15 = nonce.
  - CTR_WIDTH=64: word 12 = counter[31:0], word 13 = counter[63:32]; words 14-15 = nonce.
- FSM states: IDLE, RUN, ERR.
- cfg_ready = (state != RUN) && !abort.
- IDLE or ERR, job accepted:
  - Latch key, key256, counter, nonce, and remaining = cfg_nblocks; clear err.
  - If cfg_nblocks != 0: go to RUN. st_valid rises the next cycle (latency 1).
  - If cfg_nblocks == 0: done pulses the next cycle, state goes to IDLE, nothing is emitted.
- RUN:
  - st_valid=1 and st_last = (remaining == 1).
  - st_data, st_last and the latched fields are held stable while st_valid && !st_ready.
- RUN, transfer (st_valid && st_ready), next cycle:
  - If remaining == 1: go to IDLE and pulse done.
  - Else if counter == all-ones: go to ERR with err=1 and st_valid=0. No wrap is ever emitted; done does not pulse.
  - Else: counter += 1 (modulo 2^CTR_WIDTH, full width), remaining -= 1, and the next state is presented back-to-back (one block per cycle sustained).
- A counter of all-ones on the final block is legal (no err).
- abort, any state: next cycle state is IDLE, st_valid=0, err=0, no done pulse. A cfg_valid in the same cycle is ignored.
- Asynchronous reset mid-job discards the job immediately; all outputs return to their reset values.
- done and err are never both set in the same cycle.

Decomposition:
- Package chacha_pkg:
  - Constants SIGMA0-3 and TAU0-3.
  - Typedef word_t (32-bit).
  - Typedef state_t (512-bit).
  - Typedef gen_state_e {IDLE, RUN, ERR}.
- Sub-module chacha_state_pack: purely combinational assembly of state_t from constants, key, key256, counter and nonce. It is parametrised on CTR_WIDTH and reusable by the round core's final adder.

Test Plan:
- RFC 8439 §2.3.2 (CTR_WIDTH=32):
  - Stimulus: key = 03020100_07060504_0b0a0908_0f0e0d0c_13121110_17161514_1b1a1918_1f1e1d1c, counter = 1, nonce = 09000000_4a000000_00000000, nblocks = 1, st_ready held 1.
  - Response: st_data = {61707865,3320646e,79622d32,6b206574, key, 00000001, nonce} one cycle after acceptance; st_last=1; done pulses on the following cycle.
- Multi-block with backpressure:
  - Stimulus: nblocks = 4, counter = 0x10, st_ready toggled 1,0,0,1,1,0,1.
  - Response: counters 10,11,12,13 emitted in order, each held stable while stalled; st_last only on 13; exactly one done.
- Counter overflow:
  - Stimulus: counter = FFFFFFFE, nblocks = 3.
  - Response: FFFFFFFE and FFFFFFFF emitted; then st_valid=0 and err=1, no done. A subsequent accepted job clears err.
- 128-bit key with CTR_WIDTH=64:
  - Stimulus: key[255:128] = 00010203_04050607_08090a0b_0c0d0e0f, counter = 64'h1_FFFFFFFF, nblocks = 2.
  - Response: constants use word 1 = 3120646e and word 2 = 79622d36; key words repeat in words 4-7 and 8-11; words 12/13 = FFFFFFFF/00000001, then 00000000/00000002.
- Abort and zero-length job:
  - Stimulus: abort asserted mid-job while st_ready=0, with cfg_valid high in the same cycle.
  - Response: st_valid drops next cycle, no done, cfg not accepted.
  - Stimulus: a subsequent job with nblocks = 0.
  - Response: done pulses once with no st_valid.
- Reset mid-job:
  - Stimulus: reset asserted asynchronously during RUN.
  - Response: st_valid=0, err=0, cfg_ready=1 immediately; next job starts cleanly.
